// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - prediction state encoding and defaults for the BTB update FSM
package branch_target_buffer_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } btb_pred_e;

  localparam btb_pred_e BTB_PRED_RESET     = WEAK_NT;
  localparam int        STAT_W_DEFAULT     = 16;

endpackage

// File: rtl/btb_sat_counter.sv
// rtl/btb_sat_counter.sv - STAT_W-bit saturating event counter with sync reset and increment enable
module btb_sat_counter #(
  parameter int STAT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  output logic [STAT_W-1:0] o_count
);

  localparam logic [STAT_W-1:0] ONE = STAT_W'(1);

  logic [STAT_W-1:0] r_count;
  logic              w_at_max;

  assign w_at_max = &r_count;

  // Holds at all-ones so a long run never wraps back to a misleadingly small value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_target_buffer_fsm.sv
// rtl/branch_target_buffer_fsm.sv - 2-bit saturating prediction update for BTB write-back
// Optional statistics counters enabled by BTB_FSM_STATS_EN.
module branch_target_buffer_fsm
  import branch_target_buffer_pkg::*;
#(
  parameter int STAT_W = STAT_W_DEFAULT
) (
  input  logic              btb_fsm_clk,
  input  logic              btb_fsm_rst,
  input  logic              btb_fsm_branch_taken,
  input  logic [1:0]        btb_fsm_current_prediction,
  output logic [1:0]        btb_fsm_new_prediction,
  output logic              btb_fsm_predict_taken,
  output logic              btb_fsm_mispredict,
  output logic [STAT_W-1:0] btb_fsm_update_count,
  output logic [STAT_W-1:0] btb_fsm_mispredict_count
);

  btb_pred_e r_state;
  btb_pred_e w_cur_state;
  btb_pred_e w_next_state;
  logic      w_mispredict;
  logic      r_mispredict;

  assign w_cur_state  = btb_pred_e'(btb_fsm_current_prediction);
  // Judged against the stored prediction, before this update moves it.
  assign w_mispredict = btb_fsm_current_prediction[1] ^ btb_fsm_branch_taken;

  always_ff @(posedge btb_fsm_clk) begin
    if (btb_fsm_rst) begin
      r_state      <= BTB_PRED_RESET;
      r_mispredict <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_mispredict <= w_mispredict;
    end
  end

  always_comb begin
    w_next_state = w_cur_state;
    case (w_cur_state)
      STRONG_NT: w_next_state = btb_fsm_branch_taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   w_next_state = btb_fsm_branch_taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    w_next_state = btb_fsm_branch_taken ? STRONG_T : WEAK_NT;
      STRONG_T:  w_next_state = btb_fsm_branch_taken ? STRONG_T : WEAK_T;
      default:   w_next_state = BTB_PRED_RESET;
    endcase
  end

  assign btb_fsm_new_prediction = r_state;
  assign btb_fsm_predict_taken  = r_state[1];
  assign btb_fsm_mispredict     = r_mispredict;

`ifdef BTB_FSM_STATS_EN
  btb_sat_counter #(
    .STAT_W (STAT_W)
  ) u_update_cnt (
    .i_clk   (btb_fsm_clk),
    .i_rst   (btb_fsm_rst),
    .i_inc   (1'b1),
    .o_count (btb_fsm_update_count)
  );

  btb_sat_counter #(
    .STAT_W (STAT_W)
  ) u_mispredict_cnt (
    .i_clk   (btb_fsm_clk),
    .i_rst   (btb_fsm_rst),
    .i_inc   (w_mispredict),
    .o_count (btb_fsm_mispredict_count)
  );
`else
  assign btb_fsm_update_count     = '0;
  assign btb_fsm_mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer_fsm.sv
// tb/tb_branch_target_buffer_fsm.sv - self-checking bench for branch_target_buffer_fsm
module tb_branch_target_buffer_fsm;

  localparam int STAT_W = 4;
  localparam int CNT_MAX = (1 << STAT_W) - 1;
`ifdef BTB_FSM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              taken = 1'b0;
  logic [1:0]        cur = 2'b00;
  logic [1:0]        new_pred;
  logic              pred_taken;
  logic              mispred;
  logic [STAT_W-1:0] upd_cnt;
  logic [STAT_W-1:0] mis_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  int m_pred = 1;
  int m_mis = 0;
  int m_upd = 0;
  int m_misc = 0;

  always #5 clk = ~clk;

  branch_target_buffer_fsm #(
    .STAT_W (STAT_W)
  ) dut (
    .btb_fsm_clk                (clk),
    .btb_fsm_rst                (rst),
    .btb_fsm_branch_taken       (taken),
    .btb_fsm_current_prediction (cur),
    .btb_fsm_new_prediction     (new_pred),
    .btb_fsm_predict_taken      (pred_taken),
    .btb_fsm_mispredict         (mispred),
    .btb_fsm_update_count       (upd_cnt),
    .btb_fsm_mispredict_count   (mis_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: counter value moves one step toward the resolved direction, clamped to 0..3.
  task automatic step(input logic [1:0] c, input logic tk, input logic r, input string tag);
    int ci;
    @(negedge clk);
    cur = c;
    taken = tk;
    rst = r;
    @(posedge clk);
    #1;
    ci = int'(c);
    if (r) begin
      m_pred = 1; m_mis = 0; m_upd = 0; m_misc = 0;
    end else begin
      m_pred = tk ? ((ci + 1 > 3) ? 3 : ci + 1) : ((ci - 1 < 0) ? 0 : ci - 1);
      m_mis  = ((ci >= 2) != (tk == 1'b1)) ? 1 : 0;
      m_upd  = (m_upd + 1 > CNT_MAX) ? CNT_MAX : m_upd + 1;
      if (m_mis == 1) m_misc = (m_misc + 1 > CNT_MAX) ? CNT_MAX : m_misc + 1;
    end
    check({tag, ".new_pred"}, 32'(new_pred), 32'(m_pred));
    check({tag, ".pred_taken"}, 32'(pred_taken), (m_pred >= 2) ? 32'd1 : 32'd0);
    check({tag, ".mispredict"}, 32'(mispred), 32'(m_mis));
    check({tag, ".upd_cnt"}, 32'(upd_cnt), STATS ? 32'(m_upd) : 32'd0);
    check({tag, ".mis_cnt"}, 32'(mis_cnt), STATS ? 32'(m_misc) : 32'd0);
  endtask

  initial begin
    logic [1:0] mix_cur [7];
    logic       mix_tk  [7];
    logic [1:0] mix_exp [7];
    logic [1:0] up_exp  [4];
    logic [1:0] dn_exp  [4];
    logic [1:0] rc;
    logic       rt;
    mix_cur = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11};
    mix_tk  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    mix_exp = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10};
    up_exp  = '{2'b01, 2'b10, 2'b11, 2'b11};
    dn_exp  = '{2'b10, 2'b01, 2'b00, 2'b00};

    step(2'b11, 1'b1, 1'b1, "reset0");
    step(2'b00, 1'b0, 1'b1, "reset1");
    check("reset.new_pred_const", 32'(new_pred), 32'h1);

    for (int i = 0; i < 4; i++) begin
      step(2'(i), 1'b1, 1'b0, "upwalk");
      check("upwalk.table", 32'(new_pred), 32'(up_exp[i]));
      check("upwalk.mis_table", 32'(mispred), (i < 2) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step(2'(3 - i), 1'b0, 1'b0, "downwalk");
      check("downwalk.table", 32'(new_pred), 32'(dn_exp[i]));
      check("downwalk.mis_table", 32'(mispred), (i < 2) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 7; i++) begin
      step(mix_cur[i], mix_tk[i], 1'b0, "mixed");
      check("mixed.table", 32'(new_pred), 32'(mix_exp[i]));
    end

    step(2'b11, 1'b1, 1'b1, "midreset");
    check("midreset.not_strong_t", 32'(new_pred), 32'h1);

    // 20 updates alternating mispredict / correct, starting from cleared counters.
    for (int i = 0; i < 20; i++) begin
      rc = 2'($urandom_range(0, 3));
      rt = (i % 2 == 0) ? ~rc[1] : rc[1];
      step(rc, rt, 1'b0, "alt");
    end
    check("alt.upd_sat", 32'(upd_cnt), STATS ? 32'd15 : 32'd0);
    check("alt.mis_cnt", 32'(mis_cnt), STATS ? 32'd10 : 32'd0);

    for (int i = 0; i < 300; i++) begin
      rc = 2'($urandom_range(0, 3));
      rt = 1'($urandom_range(0, 1));
      step(rc, rt, ($urandom_range(0, 24) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer_fsm.md
# branch_target_buffer_fsm

Two-bit saturating-counter prediction update FSM for the branch target buffer (BTB). Each clock it takes the stored 2-bit prediction state of the branch being resolved and the resolved direction, and produces the updated state for write-back into the BTB entry. It also produces a taken/not-taken prediction bit and a misprediction flag. It sits between the BTB entry array and branch resolution in the execute stage.

## Interface
Parameters:
- `STAT_W`, default 16: width of the optional statistics counters.

Ports:
- `btb_fsm_clk`  input  1  sole clock; all state changes on the rising edge.
- `btb_fsm_rst`  input  1  reset, synchronous, active-high.
- `btb_fsm_branch_taken`  input  1  resolved direction of the branch: 1 = taken.
- `btb_fsm_current_prediction`  input  2  counter state currently stored in the BTB entry.
- `btb_fsm_new_prediction`  output  2  updated counter state, registered.
- `btb_fsm_predict_taken`  output  1  equals `btb_fsm_new_prediction[1]`.
- `btb_fsm_mispredict`  output  1  registered; 1 when `current_prediction[1]` differed from `branch_taken`.
- `btb_fsm_update_count`  output  `STAT_W`  number of updates performed.
- `btb_fsm_mispredict_count`  output  `STAT_W`  number of mispredictions.

## Operation
- State encoding:
  - 00 = STRONG_NT
  - 01 = WEAK_NT
  - 10 = WEAK_T
  - 11 = STRONG_T
- When taken = 1: next = current + 1, saturating at 11.
  - 00→01, 01→10, 10→11, 11→11.
- When taken = 0: next = current − 1, saturating at 00.
  - 11→10, 10→01, 01→00, 00→00.
- The next-state function is purely combinational, with no stored history. The output register captures it every cycle.
- Mispredict = `current_prediction[1] XOR branch_taken`. It is evaluated against the input state, not the updated state.
- Every non-reset clock edge is an update; there is no enable.
- Inputs must be 0/1-valued. With X/Z inputs the outputs are undefined until the next edge with known inputs or reset.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on `new_prediction`, `predict_taken` and `mispredict` after edge N.
- Reset values, applied at the first rising edge with `btb_fsm_rst` = 1:
  - `new_prediction` = 01 (WEAK_NT)
  - `predict_taken` = 0
  - `mispredict` = 0
  - both counters = 0
- Reset has priority over any update at the same edge.
- Reset asserted mid-stream discards that cycle's update.
- There is no handshake and no backpressure.

## Configuration
- Macro `BTB_FSM_STATS_EN`.
- Defined:
  - `update_count` increments by 1 on every non-reset edge.
  - `mispredict_count` increments on every non-reset edge where the mispredict condition holds.
  - Both saturate at 2^`STAT_W`−1 and never wrap.
- Undefined:
  - Both count ports remain present and are tied to constant 0.
  - No counter registers are synthesized.

## Structure
- Package `branch_target_buffer_pkg` holds:
  - typedef enum logic [1:0] `btb_pred_e` {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T};
  - constant `BTB_PRED_RESET` = WEAK_NT;
  - default `STAT_W` = 16.
- One sub-module, `btb_sat_counter`:
  - parameterized `STAT_W`-bit saturating incrementer with sync reset and increment enable;
  - instantiated twice under `BTB_FSM_STATS_EN`.

## Test plan
- Reset: hold rst = 1 for 2 edges → `new_prediction` = 01, `mispredict` = 0, counts = 0.
- Full up-walk: current 00/01/10/11 each with taken = 1, one per cycle → outputs 01, 10, 11, 11 one cycle later. `mispredict` = 1, 1, 0, 0.
- Full down-walk: current 11/10/01/00 with taken = 0 → 10, 01, 00, 00. `mispredict` = 1, 1, 0, 0.
- Mixed sequence (current, taken):
  - input (11,0), (10,0), (00,1), (01,0), (00,1), (01,1), (11,0)
  - → `new_prediction` 10, 01, 01, 00, 01, 10, 10
  - → `predict_taken` 1, 0, 0, 0, 0, 1, 1
- Mid-stream reset: assert rst on the edge where input is (11,1) → output 01, not 11. Counters clear.
- With `BTB_FSM_STATS_EN` and `STAT_W` = 4, 20 updates with alternating mispredicts:
  - `update_count` saturates at 15;
  - `mispredict_count` = 10, or 15 if more than 15 mispredicts occur.
  - Without the macro, both counts read 0.
